link_training_sequencer: RTL and testbench
==========================================

LINK_TRAINING_SEQUENCER -- requirements
Module: link_training_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
- QUIET_CYCLES, 64: dwell time in Detect states.
- TIMEOUT_CYCLES, 1024: per-substate timeout.
- RX_REQ, 8: consecutive matching OS required in Polling and Config.Complete.
- RX_CFG, 2: consecutive matching OS required in Config.LinkWidth/Lanenum states.
- TX_MIN, 16: minimum OS to transmit before leaving a TS state.
- IDLE_REQ, 8: consecutive idle symbols required in Config.Idle.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state changes on the rising edge.
- reset, in, 1: asynchronous, active-low.
- start, in, 1: enable training; low forces Detect.Quiet.
- receiver_detected, in, 1: far-end receiver present.
- os_count, in, 8: consecutive-match count from the checker's counter.
- rx_idle, in, 1: idle symbol received this cycle.
- tx_done, in, 1: one-cycle pulse per transmitted OS.
- substate, out, 4: substate driven to the checker.
- reset_checker, out, 1: active-low clear to the checker and counter.
- tx_enable, out, 1: transmitter on.
- tx_os_type, out, 2: OS to send; 0 none, 1 TS1, 2 TS2, 3 IDL.
- link_up, out, 1: link trained.
- timeout_err, out, 1: one-cycle timeout pulse.

Function
REQ-003 State encodings on substate:
- DQ=0, DA=1, PA=2, PC=3
- CLWS=4, CLWA=5, CLNW=6, CLNA=7
- CC=8, CI=9, L0=10
- Values 11-15 are illegal and SHALL return to DQ on the next clock.
REQ-004 A 16-bit state timer SHALL clear on every state change, increment each cycle otherwise, and saturate at 0xFFFF.
REQ-005 A tx counter (8-bit, saturating) SHALL clear on state change and increment on each tx_done.
REQ-006 An idle counter (8-bit, saturating) SHALL count consecutive rx_idle cycles in CI and clear on any cycle with rx_idle=0.
REQ-007 reset_checker SHALL be low for exactly the one cycle following any state change, high otherwise.
REQ-008 os_count SHALL be ignored during the entry cycle of a state and during the cycle reset_checker is low.
REQ-009 DQ: tx off. Go to DA when timer reaches QUIET_CYCLES-1 and start=1.
REQ-010 DA: if receiver_detected=1, go to PA; else return to DQ at timer = QUIET_CYCLES-1.
REQ-011 PA: send TS1. Go to PC when os_count>=RX_REQ and tx counter>=TX_MIN.
REQ-012 PC: send TS2. Go to CLWS under the same condition as REQ-011.
REQ-013 CLWS, CLWA, CLNW and CLNA: send TS1. Each advances to the next state (4 to 5 to 6 to 7 to 8) when os_count>=RX_CFG.
REQ-014 CC: send TS2. Go to CI when os_count>=RX_REQ and tx counter>=TX_MIN.
REQ-015 CI: send IDL. Go to L0 when idle counter>=IDLE_REQ and tx counter>=TX_MIN.
REQ-016 L0: link_up=1, tx_os_type=0, tx_enable=0. Remain in L0 until start=0.
REQ-017 Timeout: in states PA through CI, timer = TIMEOUT_CYCLES-1 without meeting the exit condition SHALL go to DQ and pulse timeout_err for one cycle.
REQ-018 Priority when events coincide in the same cycle: start=0 first, then exit condition, then timeout.
REQ-019 start=0 in any state SHALL go to DQ on the next clock, with no timeout_err.
REQ-020 link_up SHALL be combinational from state (state==L0); tx_os_type and tx_enable SHALL be registered with state (no lag).

Reset
REQ-021 While reset=0, all outputs SHALL be held at their reset values:
- substate=0, reset_checker=0
- tx_enable=0, tx_os_type=0
- link_up=0, timeout_err=0
- all counters 0
REQ-022 Reset assertion mid-training SHALL take effect immediately (asynchronously). After release, the block SHALL start in DQ with reset_checker=0 for the first clock.

Verification
REQ-023 Happy path: start=1, receiver_detected=1, os_count=8 after each entry, tx_done every cycle, rx_idle=1 -> state sequence 0,1,2,...,9,10; link_up=1; exactly one reset_checker low pulse per transition.
REQ-024 Threshold boundary: in PA, os_count=7 with tx count 20 -> remain in PA; os_count=8 with tx count 15 -> remain; both conditions met -> PC next cycle.
REQ-025 Timeout: in CLWS with os_count=1 held -> DQ at timer 1023, timeout_err high for exactly one cycle.
REQ-026 Idle break: in CI with rx_idle pattern 7x1, 0, 8x1 -> L0 only after the second run completes.
REQ-027 Abort: start=0 in CC -> DQ next cycle, timeout_err=0; reset=0 in PC -> substate=0 immediately, without waiting for a clock.
REQ-028 Entry-cycle masking: os_count held at 8 across the PC-to-CLWS transition -> CLWS does not advance in its first two cycles.

Source files
------------

// File: rtl/link_training_if.sv
// -----------------------------------------------------------------------------
// link_training_if
//   Bundles the signals between the link training sequencer and the
//   receive checker / transmitter it controls.
//
//   From the PHY side into the sequencer:
//     start              enable training; low forces Detect.Quiet
//     receiver_detected  far-end receiver present
//     os_count[7:0]      consecutive-match count from the checker's counter
//     rx_idle            idle symbol received this cycle
//     tx_done            one-cycle pulse per transmitted ordered set
//   From the sequencer out to the PHY side:
//     substate[3:0]      current training substate, driven to the checker
//     reset_checker      active-low clear to the checker and its counter
//     tx_enable          transmitter on
//     tx_os_type[1:0]    ordered set to send: 0 none, 1 TS1, 2 TS2, 3 IDL
//     link_up            link trained
//     timeout_err        one-cycle pulse when a substate times out
//
//   Modports: master = the sequencer, slave = the PHY / checker side.
// -----------------------------------------------------------------------------
interface link_training_if;
  logic       start;
  logic       receiver_detected;
  logic [7:0] os_count;
  logic       rx_idle;
  logic       tx_done;
  logic [3:0] substate;
  logic       reset_checker;
  logic       tx_enable;
  logic [1:0] tx_os_type;
  logic       link_up;
  logic       timeout_err;

  modport master (
    input  start, receiver_detected, os_count, rx_idle, tx_done,
    output substate, reset_checker, tx_enable, tx_os_type, link_up, timeout_err
  );

  modport slave (
    output start, receiver_detected, os_count, rx_idle, tx_done,
    input  substate, reset_checker, tx_enable, tx_os_type, link_up, timeout_err
  );
endinterface

// File: rtl/link_training_sequencer.sv
// -----------------------------------------------------------------------------
// link_training_sequencer
//   Walks a serial link through Detect -> Polling -> Configuration -> L0.
//   Each substate has a dwell timer, a transmitted-OS counter and (in
//   Config.Idle) a consecutive-idle counter; exits are gated on the
//   checker's os_count, which is ignored for the first two cycles of every
//   substate while the checker is being cleared.
//
//   Ports:
//     clk    single clock, rising edge
//     reset  asynchronous, active-low
//     lt     link_training_if.master (see the interface for signal list)
//
//   Parameters:
//     QUIET_CYCLES    dwell time in the Detect substates
//     TIMEOUT_CYCLES  per-substate timeout, Polling.Active through Config.Idle
//     RX_REQ          matching OS needed in Polling and Config.Complete
//     RX_CFG          matching OS needed in the Config.LinkWidth/Lanenum states
//     TX_MIN          OS that must be sent before leaving a TS/IDL substate
//     IDLE_REQ        consecutive idle symbols needed in Config.Idle
// -----------------------------------------------------------------------------
module link_training_sequencer #(
  parameter int unsigned QUIET_CYCLES   = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned RX_REQ         = 8,
  parameter int unsigned RX_CFG         = 2,
  parameter int unsigned TX_MIN         = 16,
  parameter int unsigned IDLE_REQ       = 8
) (
  input  logic            clk,
  input  logic            reset,
  link_training_if.master lt
);

  typedef enum logic [3:0] {
    ST_DQ   = 4'd0,   // Detect.Quiet
    ST_DA   = 4'd1,   // Detect.Active
    ST_PA   = 4'd2,   // Polling.Active
    ST_PC   = 4'd3,   // Polling.Configuration
    ST_CLWS = 4'd4,   // Config.LinkWidth.Start
    ST_CLWA = 4'd5,   // Config.LinkWidth.Accept
    ST_CLNW = 4'd6,   // Config.Lanenum.Wait
    ST_CLNA = 4'd7,   // Config.Lanenum.Accept
    ST_CC   = 4'd8,   // Config.Complete
    ST_CI   = 4'd9,   // Config.Idle
    ST_L0   = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    OS_NONE = 2'd0,
    OS_TS1  = 2'd1,
    OS_TS2  = 2'd2,
    OS_IDL  = 2'd3
  } os_e;

  localparam logic [15:0] QUIET_LAST   = 16'(QUIET_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  RX_REQ_C     = 8'(RX_REQ);
  localparam logic [7:0]  RX_CFG_C     = 8'(RX_CFG);
  localparam logic [7:0]  TX_MIN_C     = 8'(TX_MIN);
  localparam logic [7:0]  IDLE_REQ_C   = 8'(IDLE_REQ);

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  tx_cnt_q, tx_cnt_d;
  logic [7:0]  idle_cnt_q, idle_cnt_d;
  logic        entry_q, entry_d;          // high in the first cycle of a substate
  logic        rst_chk_q, rst_chk_d;
  logic        timeout_q, timeout_d;
  os_e         tx_os_type_q, tx_os_type_d;
  logic        tx_enable_q, tx_enable_d;

  logic        os_valid;
  logic        ts_exit_ok, cfg_exit_ok, idle_exit_ok;
  logic        timed_state, exit_ok;
  state_e      exit_state;
  logic        state_change;

  // The checker is cleared in the cycle after entry, so its count is only
  // trustworthy once both the entry cycle and the clear cycle have passed.
  assign os_valid     = !entry_q && rst_chk_q;
  assign ts_exit_ok   = os_valid && (lt.os_count >= RX_REQ_C) && (tx_cnt_q >= TX_MIN_C);
  assign cfg_exit_ok  = os_valid && (lt.os_count >= RX_CFG_C);
  assign idle_exit_ok = (idle_cnt_q >= IDLE_REQ_C) && (tx_cnt_q >= TX_MIN_C);

  // Next-state logic. Priority: start=0, then the exit condition, then timeout.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // through the case statements leaves a signal unassigned (no latches).
    state_d     = state_q;
    timeout_d   = 1'b0;
    timed_state = 1'b0;
    exit_ok     = 1'b0;
    exit_state  = ST_DQ;

    case (state_q)
      ST_PA:   begin timed_state = 1'b1; exit_ok = ts_exit_ok;   exit_state = ST_PC;   end
      ST_PC:   begin timed_state = 1'b1; exit_ok = ts_exit_ok;   exit_state = ST_CLWS; end
      ST_CLWS: begin timed_state = 1'b1; exit_ok = cfg_exit_ok;  exit_state = ST_CLWA; end
      ST_CLWA: begin timed_state = 1'b1; exit_ok = cfg_exit_ok;  exit_state = ST_CLNW; end
      ST_CLNW: begin timed_state = 1'b1; exit_ok = cfg_exit_ok;  exit_state = ST_CLNA; end
      ST_CLNA: begin timed_state = 1'b1; exit_ok = cfg_exit_ok;  exit_state = ST_CC;   end
      ST_CC:   begin timed_state = 1'b1; exit_ok = ts_exit_ok;   exit_state = ST_CI;   end
      ST_CI:   begin timed_state = 1'b1; exit_ok = idle_exit_ok; exit_state = ST_L0;   end
      default: ;
    endcase

    if (!lt.start) begin
      state_d = ST_DQ;
    end else if (timed_state) begin
      if (exit_ok) begin
        state_d = exit_state;
      end else if (timer_q == TIMEOUT_LAST) begin
        state_d   = ST_DQ;
        timeout_d = 1'b1;
      end
    end else begin
      case (state_q)
        // ">=" rather than "==": the timer keeps running while start is low,
        // so the quiet period may already be over when start rises.
        ST_DQ:   state_d = (timer_q >= QUIET_LAST) ? ST_DA : ST_DQ;
        ST_DA: begin
          if (lt.receiver_detected)      state_d = ST_PA;
          else if (timer_q >= QUIET_LAST) state_d = ST_DQ;
        end
        ST_L0:   state_d = ST_L0;
        default: state_d = ST_DQ;       // encodings 11-15 are illegal
      endcase
    end
  end

  // Counters, checker clear and transmit controls for the next cycle.
  always_comb begin
    state_change = (state_d != state_q);

    timer_d  = state_change ? 16'd0
             : (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

    tx_cnt_d = tx_cnt_q;
    if (state_change)                          tx_cnt_d = 8'd0;
    else if (lt.tx_done && tx_cnt_q != 8'hFF)  tx_cnt_d = tx_cnt_q + 8'd1;

    idle_cnt_d = 8'd0;
    if (!state_change && state_q == ST_CI && lt.rx_idle)
      idle_cnt_d = (idle_cnt_q == 8'hFF) ? idle_cnt_q : idle_cnt_q + 8'd1;

    entry_d   = state_change;
    rst_chk_d = !entry_q;               // low exactly one cycle after entry

    // Transmit controls follow state_d so they change together with substate.
    case (state_d)
      ST_PA, ST_CLWS, ST_CLWA, ST_CLNW, ST_CLNA: tx_os_type_d = OS_TS1;
      ST_PC, ST_CC:                              tx_os_type_d = OS_TS2;
      ST_CI:                                     tx_os_type_d = OS_IDL;
      default:                                   tx_os_type_d = OS_NONE;
    endcase
    tx_enable_d = (tx_os_type_d != OS_NONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_DQ;
      timer_q      <= 16'd0;
      tx_cnt_q     <= 8'd0;
      idle_cnt_q   <= 8'd0;
      // NOTE: entry_q resets low so reset_checker, which also resets low,
      // rises after the first clock instead of staying low for two cycles.
      entry_q      <= 1'b0;
      rst_chk_q    <= 1'b0;
      timeout_q    <= 1'b0;
      tx_os_type_q <= OS_NONE;
      tx_enable_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the values from before this edge, independent of order.
      state_q      <= state_d;
      timer_q      <= timer_d;
      tx_cnt_q     <= tx_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      entry_q      <= entry_d;
      rst_chk_q    <= rst_chk_d;
      timeout_q    <= timeout_d;
      tx_os_type_q <= tx_os_type_d;
      tx_enable_q  <= tx_enable_d;
    end
  end

  assign lt.substate      = state_q;
  assign lt.reset_checker = rst_chk_q;
  assign lt.tx_enable     = tx_enable_q;
  assign lt.tx_os_type    = tx_os_type_q;
  assign lt.link_up       = (state_q == ST_L0);
  assign lt.timeout_err   = timeout_q;

endmodule

// File: tb/tb_link_training_sequencer.sv
// -----------------------------------------------------------------------------
// tb_link_training_sequencer
//   Directed scenarios (happy path, thresholds, timeout, idle break, aborts)
//   followed by randomized stimulus. A behavioural model tracks substate,
//   cycles spent in it, OS sent and idle run, and a compare process checks
//   every DUT output against it on each falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_link_training_sequencer;

  localparam int QUIET = 64;
  localparam int TMO   = 1024;
  localparam int RXR   = 8;
  localparam int RXC   = 2;
  localparam int TXM   = 16;
  localparam int IDR   = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  link_training_if lt();

  link_training_sequencer #(
    .QUIET_CYCLES(QUIET), .TIMEOUT_CYCLES(TMO), .RX_REQ(RXR),
    .RX_CFG(RXC), .TX_MIN(TXM), .IDLE_REQ(IDR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .lt    (lt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // st: substate number, age: cycles since entering it, tx: OS sent since
  // entry, idle: current idle run in Config.Idle. chg1/chg2 remember whether
  // the last / second-to-last edge changed substate (reset counts as one).
  typedef struct {
    int st; int age; int tx; int idle; bit to; bit chg1; bit chg2;
  } mdl_t;

  mdl_t m = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b1};

  function automatic mdl_t model_next(mdl_t c, bit start, bit rxdet, int os, bit txd, bit idle);
    mdl_t n     = c;
    int   nxt   = c.st;
    bit   to    = 1'b0;
    bit   os_ok = (c.age >= 2);
    bit   done  = 1'b0;
    if (!start) nxt = 0;
    else if (c.st == 0) begin
      if (c.age >= QUIET - 1) nxt = 1;
    end else if (c.st == 1) begin
      if (rxdet) nxt = 2;
      else if (c.age >= QUIET - 1) nxt = 0;
    end else if (c.st == 10) begin
      nxt = 10;
    end else begin
      if (c.st == 2 || c.st == 3 || c.st == 8) done = os_ok && os >= RXR && c.tx >= TXM;
      else if (c.st >= 4 && c.st <= 7)         done = os_ok && os >= RXC;
      else                                     done = (c.idle >= IDR) && (c.tx >= TXM);
      if (done) nxt = c.st + 1;
      else if (c.age == TMO - 1) begin nxt = 0; to = 1'b1; end
    end
    n.st   = nxt;
    n.to   = to;
    n.chg2 = c.chg1;
    n.chg1 = (nxt != c.st);
    if (nxt != c.st) begin
      n.age = 0; n.tx = 0; n.idle = 0;
    end else begin
      n.age  = (c.age < 65535) ? c.age + 1 : c.age;
      n.tx   = (txd && c.tx < 255) ? c.tx + 1 : c.tx;
      n.idle = (c.st == 9 && idle) ? ((c.idle < 255) ? c.idle + 1 : c.idle) : 0;
    end
    return n;
  endfunction

  function automatic logic [9:0] model_out(mdl_t c);
    logic [1:0] ty;
    case (c.st)
      2, 4, 5, 6, 7: ty = 2'd1;
      3, 8:          ty = 2'd2;
      9:             ty = 2'd3;
      default:       ty = 2'd0;
    endcase
    return {4'(c.st), ~c.chg2, (ty != 2'd0), ty, (c.st == 10), c.to};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= '{0, 0, 0, 0, 1'b0, 1'b0, 1'b1};
    else m <= model_next(m, lt.start, lt.receiver_detected, int'(lt.os_count),
                         lt.tx_done, lt.rx_idle);
  end

  // Single compare process: all outputs against the model, every cycle.
  always @(negedge clk) begin
    if (cmp_en)
      check("cycle_outputs",
            {22'd0, lt.substate, lt.reset_checker, lt.tx_enable, lt.tx_os_type,
             lt.link_up, lt.timeout_err},
            {22'd0, model_out(m)});
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_until(input int st, input int budget, input string name);
    int n = 0;
    while (lt.substate !== 4'(st) && n < budget) begin
      tick();
      n++;
    end
    check(name, {31'd0, lt.substate === 4'(st)}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[$];
    int last, n, l0_at, low_cnt, clws_dwell, pulses, left;

    lt.start = 1'b0; lt.receiver_detected = 1'b0; lt.os_count = 8'd0;
    lt.rx_idle = 1'b0; lt.tx_done = 1'b0;
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    repeat (3) tick();
    check("rst_substate",      {28'd0, lt.substate}, 32'd0);
    check("rst_reset_checker", {31'd0, lt.reset_checker}, 32'd0);
    check("rst_tx_enable",     {31'd0, lt.tx_enable}, 32'd0);
    check("rst_tx_os_type",    {30'd0, lt.tx_os_type}, 32'd0);
    check("rst_link_up",       {31'd0, lt.link_up}, 32'd0);
    check("rst_timeout_err",   {31'd0, lt.timeout_err}, 32'd0);

    // Happy path: everything favourable from the first cycle after reset.
    lt.start = 1'b1; lt.receiver_detected = 1'b1; lt.os_count = 8'd8;
    lt.tx_done = 1'b1; lt.rx_idle = 1'b1;
    reset = 1'b1;
    last = 0; n = 0; l0_at = -1; low_cnt = 0; clws_dwell = 0;
    while (l0_at < 0 && n < 400) begin
      tick(); n++;
      if (!lt.reset_checker) low_cnt++;
      if (lt.substate == 4'd4) clws_dwell++;
      if (int'(lt.substate) != last) begin
        last = int'(lt.substate);
        seq.push_back(last);
      end
      if (lt.link_up) l0_at = n;
    end
    tick();
    if (!lt.reset_checker) low_cnt++;
    check("happy_l0_cycle", l0_at, 145);
    check("happy_seq_len", seq.size(), 10);
    for (int i = 0; i < seq.size() && i < 10; i++) check("happy_seq", seq[i], i + 1);
    check("happy_rc_low_cycles", low_cnt, 10);
    check("clws_entry_mask_dwell", clws_dwell, 3);
    check("happy_link_up", {31'd0, lt.link_up}, 32'd1);

    lt.start = 1'b0;
    tick();
    check("l0_drop_start_dq", {28'd0, lt.substate}, 32'd0);

    // Threshold boundaries in Polling.Active.
    lt.start = 1'b1; lt.os_count = 8'd0; lt.tx_done = 1'b0;
    run_until(2, 200, "reach_pa");
    lt.os_count = 8'd8; lt.tx_done = 1'b1;
    repeat (15) tick();
    lt.tx_done = 1'b0;
    repeat (5) begin tick(); check("pa_tx15_hold", {28'd0, lt.substate}, 32'd2); end
    lt.os_count = 8'd7; lt.tx_done = 1'b1;
    repeat (5) begin tick(); check("pa_os7_hold", {28'd0, lt.substate}, 32'd2); end
    lt.os_count = 8'd8; lt.tx_done = 1'b0;
    tick();
    check("pa_both_exit_pc", {28'd0, lt.substate}, 32'd3);

    // Timeout in Config.LinkWidth.Start.
    lt.tx_done = 1'b1;
    run_until(4, 100, "reach_clws");
    lt.os_count = 8'd1;
    n = 0; pulses = 0;
    while (lt.substate != 4'd0 && n < 1100) begin
      tick(); n++;
      if (lt.timeout_err) pulses++;
    end
    check("clws_timeout_cycles", n, 1024);
    check("timeout_at_dq", {31'd0, lt.timeout_err}, 32'd1);
    repeat (3) begin tick(); if (lt.timeout_err) pulses++; end
    check("timeout_pulse_count", pulses, 1);

    // Idle run broken once in Config.Idle.
    lt.os_count = 8'd8; lt.rx_idle = 1'b0;
    run_until(9, 400, "reach_ci");
    left = -1;
    for (int a = 0; a < 40 && left < 0; a++) begin
      lt.rx_idle = ((a >= 10 && a <= 16) || a >= 18);
      tick();
      if (lt.substate != 4'd9) left = a + 1;
    end
    check("ci_idle_break_dwell", left, 27);
    check("ci_exit_to_l0", {28'd0, lt.substate}, 32'd10);

    // Abort with start=0 in Config.Complete.
    lt.start = 1'b0; tick(); lt.start = 1'b1;
    run_until(8, 300, "reach_cc");
    lt.start = 1'b0;
    tick();
    check("cc_abort_dq", {28'd0, lt.substate}, 32'd0);
    check("cc_abort_no_timeout", {31'd0, lt.timeout_err}, 32'd0);
    lt.start = 1'b1;

    // Asynchronous reset in Polling.Configuration, between clock edges.
    run_until(3, 300, "reach_pc");
    #2 reset = 1'b0;
    #1;
    check("async_rst_substate", {28'd0, lt.substate}, 32'd0);
    check("async_rst_reset_checker", {31'd0, lt.reset_checker}, 32'd0);
    check("async_rst_tx_enable", {31'd0, lt.tx_enable}, 32'd0);
    tick(); tick();
    reset = 1'b1;

    // Randomized stimulus against the model.
    for (int i = 0; i < 8000; i++) begin
      lt.start             = ($urandom_range(0, 299) != 0);
      lt.receiver_detected = $urandom_range(0, 1);
      lt.os_count          = 8'($urandom_range(0, 12));
      lt.tx_done           = ($urandom_range(0, 3) != 0);
      lt.rx_idle           = ($urandom_range(0, 9) != 0);
      if (i % 2500 == 1234) begin
        #3 reset = 1'b0;
        tick();
        reset = 1'b1;
      end
      tick();
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
